relm_push_fifo: RTL
===================

RELM_PUSH_FIFO -- requirements
Module: relm_push_fifo

Interface
REQ-001 The block SHALL have parameter WD, default 32, the data word width matching the processor push port.
REQ-002 The block SHALL have parameter WAF, default 4, the log2 of the FIFO depth (depth = 2**WAF).
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 Port: clk  input  1  rising-edge clock for all state.
REQ-005 Port: rst_n_in  input  1  synchronous active-low reset.
REQ-006 Port: push_in  input  WD+1  processor push word; bit WD is the write strobe, bits [WD-1:0] are the data.
REQ-007 Port: retry_out  output  1  push refused this cycle; the processor reissues the push.
REQ-008 Port: q_out  output  WD  head-of-FIFO data for the downstream consumer.
REQ-009 Port: valid_out  output  1  q_out holds a valid word.
REQ-010 Port: ready_in  input  1  consumer accepts q_out when valid_out and ready_in are both 1.
REQ-011 Port: count_out  output  WAF+1  number of words held, 0..2**WAF.

Function
REQ-012 A push SHALL be accepted when push_in[WD]=1 and retry_out=0; it writes push_in[WD-1:0] at the write pointer and increments the write pointer modulo 2**WAF.
REQ-013 retry_out SHALL equal (count_out == 2**WAF) and SHALL be derived only from registered state, with no combinational path from push_in or ready_in.
REQ-014 A strobed push while retry_out=1 SHALL be discarded, with no change to memory, pointers or count.
REQ-015 A pop SHALL occur when valid_out=1 and ready_in=1; the read pointer increments modulo 2**WAF.
REQ-016 valid_out SHALL equal (count_out != 0), and q_out SHALL show the word at the read pointer.
REQ-017 A word pushed into an empty FIFO at edge N SHALL appear on q_out with valid_out=1 after edge N (1-cycle latency).
REQ-018 An accepted push and a pop in the same cycle SHALL leave count unchanged and advance both pointers.
REQ-019 When full, a same-cycle pop and push SHALL perform the pop only, because retry_out is already 1.
REQ-020 When empty, ready_in SHALL have no effect.
REQ-021 A push and a pop SHALL wrap both pointers from 2**WAF-1 to 0 without data loss.
REQ-022 Words SHALL be delivered strictly in push order, with no duplication or loss of accepted words.

Reset
REQ-023 While rst_n_in=0 at a clock edge, the block SHALL clear both pointers and the count, and drive valid_out=0, retry_out=0 and count_out=0.
REQ-024 Reset SHALL override a simultaneous push or pop, and words held before reset SHALL be lost.
REQ-025 Memory contents SHALL need no reset; q_out is don't-care while valid_out=0.

Configuration
REQ-026 With macro RELM_PUSH_FIFO_DROP_EN defined, the block SHALL add output drop_out (16 bits), a count of discarded strobed pushes that saturates at 0xFFFF and is cleared by reset.
REQ-027 Without RELM_PUSH_FIFO_DROP_EN, port drop_out and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification (WD=32, WAF=2, depth 4)
REQ-028 Push 0x11 with ready_in=0 -> valid_out=1, q_out=0x11 and count_out=1 next cycle.
REQ-029 Push 0xA0..0xA3 then strobe 0xA4 with ready_in=0 -> retry_out=1 after the fourth push; 0xA4 is discarded; count stays 4; drop_out=1 when enabled.
REQ-030 FIFO full, push 0xB0 with ready_in=1 in the same cycle -> 0xA0 popped, 0xB0 refused, count_out=3, retry_out=0 next cycle.
REQ-031 Stream 10 words 0x1..0xA with ready_in=1 throughout -> consumer sees 0x1..0xA in order across pointer wrap; count stays at most 1.
REQ-032 Hold 3 words, assert rst_n_in=0 for 1 cycle while pushing 0xC0 -> count_out=0, valid_out=0, retry_out=0 afterwards; 0xC0 not stored.
REQ-033 With RELM_PUSH_FIFO_DROP_EN defined, 70000 refused pushes -> drop_out=0xFFFF, held with no wrap.

Source files
------------

// File: rtl/relm_push_fifo.sv
// Processor push-port FIFO: single clock, synchronous active-low reset, refuses pushes when full.
// Optional macro RELM_PUSH_FIFO_DROP_EN adds a saturating 16-bit count of refused pushes on drop_out.
module relm_push_fifo #(
  parameter int WD  = 32,
  parameter int WAF = 4
) (
  input  logic          clk,
  input  logic          rst_n_in,
  input  logic [WD:0]   push_in,
  output logic          retry_out,
  output logic [WD-1:0] q_out,
  output logic          valid_out,
  input  logic          ready_in,
  output logic [WAF:0]  count_out
`ifdef RELM_PUSH_FIFO_DROP_EN
  ,
  output logic [15:0]   drop_out
`endif
);

  localparam int DEPTH = 1 << WAF;
  localparam logic [WAF:0]   FULL_CNT = {1'b1, {WAF{1'b0}}};
  localparam logic [WAF:0]   ONE_CNT  = (WAF+1)'(1);
  localparam logic [WAF-1:0] ONE_PTR  = WAF'(1);

  logic [WD-1:0]  mem_r [DEPTH];
  logic [WAF-1:0] wr_ptr_r;
  logic [WAF-1:0] rd_ptr_r;
  logic [WAF:0]   count_r;
  logic           valid_r;
  logic           full_r;

  logic           push_ok_s;
  logic           pop_ok_s;
  logic [WAF:0]   count_nxt_s;

  // Accept/pop decisions and next occupancy; all qualifiers come from registered flags.
  always_comb begin
    push_ok_s   = push_in[WD] & ~full_r;
    pop_ok_s    = valid_r & ready_in;
    count_nxt_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + ONE_CNT;
      2'b01:   count_nxt_s = count_r - ONE_CNT;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer, occupancy and status flag registers; flags precomputed so outputs stay registered.
  always_ff @(posedge clk) begin
    if (!rst_n_in) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      valid_r  <= 1'b0;
      full_r   <= 1'b0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + ONE_PTR;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + ONE_PTR;
      count_r <= count_nxt_s;
      valid_r <= (count_nxt_s != '0);
      full_r  <= (count_nxt_s == FULL_CNT);
    end
  end

  // Storage array; contents are not reset, a push coinciding with reset is not written.
  always_ff @(posedge clk) begin
    if (push_ok_s && rst_n_in) begin
      mem_r[wr_ptr_r] <= push_in[WD-1:0];
    end
  end

`ifdef RELM_PUSH_FIFO_DROP_EN
  logic [15:0] drop_r;

  // Saturating count of strobed pushes refused because the FIFO was full.
  always_ff @(posedge clk) begin
    if (!rst_n_in) begin
      drop_r <= 16'h0000;
    end else if (push_in[WD] && full_r && (drop_r != 16'hFFFF)) begin
      drop_r <= drop_r + 16'h0001;
    end
  end

  assign drop_out = drop_r;
`endif

  assign retry_out = full_r;
  assign valid_out = valid_r;
  assign count_out = count_r;
  assign q_out     = mem_r[rd_ptr_r];

endmodule
